// File: rtl/instruction_decoder_params.sv
// Shared micro-instruction format definitions: field positions, opcodes,
// the encoder state type, and helpers that pack encoder words.
package instruction_decoder_params;

  localparam int INSTR_W        = 32;
  localparam int WR_DATA_W      = 16;
  localparam int WR_ADDR_W      = 14;
  localparam int RD_ADDR_W      = 14;
  localparam int BURST_W        = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_GO    = 2'b10;

  localparam int OP_MSB       = 31;
  localparam int OP_LSB       = 30;
  localparam int WR_ADDR_MSB  = 29;
  localparam int WR_ADDR_LSB  = 16;
  localparam int WR_DATA_MSB  = 15;
  localparam int WR_DATA_LSB  = 0;
  localparam int RD_START_MSB = 28;
  localparam int RD_START_LSB = 15;
  localparam int RD_END_MSB   = 13;
  localparam int RD_END_LSB   = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } enc_state_t;

  function automatic logic [INSTR_W-1:0] pack_write(input logic [WR_ADDR_W-1:0] addr,
                                                    input logic [WR_DATA_W-1:0] data);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]           = OP_WRITE;
    w[WR_ADDR_MSB:WR_ADDR_LSB] = addr;
    w[WR_DATA_MSB:WR_DATA_LSB] = data;
    return w;
  endfunction

  // Bits 29 and 14 are reserved and stay zero.
  function automatic logic [INSTR_W-1:0] pack_read(input logic [RD_ADDR_W-1:0] start_addr,
                                                   input logic [RD_ADDR_W-1:0] end_addr);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]             = OP_READ;
    w[RD_START_MSB:RD_START_LSB] = start_addr;
    w[RD_END_MSB:RD_END_LSB]     = end_addr;
    return w;
  endfunction

  function automatic logic [INSTR_W-1:0] pack_go();
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = OP_GO;
    return w;
  endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Host command, write-data and instruction-stream handshakes of the encoder.
interface instruction_encoder_if;
  import instruction_decoder_params::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [RD_ADDR_W-1:0] cmd_addr;
  logic [RD_ADDR_W-1:0] cmd_end_addr;
  logic [BURST_W-1:0]   cmd_len;
  logic                 wdata_valid;
  logic                 wdata_ready;
  logic [WR_DATA_W-1:0] wdata;
  logic                 instr_valid;
  logic                 instr_ready;
  logic [INSTR_W-1:0]   instr;
  logic                 busy;
  logic                 err;
  logic [15:0]          instr_count;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_end_addr, cmd_len,
    output wdata_valid, wdata, instr_ready,
    input  cmd_ready, wdata_ready, instr_valid, instr, busy, err, instr_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_end_addr, cmd_len,
    input  wdata_valid, wdata, instr_ready,
    output cmd_ready, wdata_ready, instr_valid, instr, busy, err, instr_count
  );

endinterface

// File: rtl/instr_fifo.sv
// Small synchronous FIFO with a combinational head that reads zero when empty.
module instr_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even if the head is popped on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/instruction_encoder.sv
// Packs host commands (write burst, read range, go) into 32-bit
// micro-instructions and streams them out through a small FIFO.
module instruction_encoder
  import instruction_decoder_params::*;
#(
  parameter int INSTR_LENGTH         = INSTR_W,
  parameter int WRITE_DATA_LENGTH    = WR_DATA_W,
  parameter int WRITE_ADDRESS_LENGTH = WR_ADDR_W,
  parameter int READ_ADDRESS_LENGTH  = RD_ADDR_W,
  parameter int BURST_LEN_WIDTH      = BURST_W,
  parameter int FIFO_DEPTH           = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_encoder_if.slave  bus
);

  enc_state_t                      state_reg;
  logic [WRITE_ADDRESS_LENGTH-1:0] addr_reg;
  logic [BURST_LEN_WIDTH-1:0]      remaining_reg;
  logic                            err_reg;
  logic [15:0]                     instr_count_reg;

  logic                            fifo_full;
  logic                            fifo_empty;
  logic [INSTR_LENGTH-1:0]         fifo_head;
  logic                            push;
  logic [INSTR_LENGTH-1:0]         push_data;

  logic                            cmd_fire;
  logic                            wdata_fire;
  logic                            instr_fire;
  logic                            cmd_reject;
  logic [READ_ADDRESS_LENGTH-1:0]  rd_start;
  logic [READ_ADDRESS_LENGTH-1:0]  rd_end;
  logic [WRITE_DATA_LENGTH-1:0]    wr_data;

  assign rd_start = bus.cmd_addr;
  assign rd_end   = bus.cmd_end_addr;
  assign wr_data  = bus.wdata;

  // cmd_ready is held low while reset is asserted so nothing is accepted then.
  assign bus.cmd_ready   = !rst && (state_reg == IDLE) && !fifo_full;
  assign bus.wdata_ready = (state_reg == WRITE) && !fifo_full;

  assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
  assign wdata_fire = bus.wdata_valid && bus.wdata_ready;
  assign instr_fire = !fifo_empty && bus.instr_ready;

  always_comb begin
    cmd_reject = 1'b0;
    case (bus.cmd_op)
      OP_WRITE: cmd_reject = 1'b0;
      OP_READ:  cmd_reject = (rd_start > rd_end);
      OP_GO:    cmd_reject = 1'b0;
      default:  cmd_reject = 1'b1;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (state_reg == WRITE) begin
      push      = wdata_fire;
      push_data = pack_write(addr_reg, wr_data);
    end else if (cmd_fire && !cmd_reject) begin
      if (bus.cmd_op == OP_READ) begin
        push      = 1'b1;
        push_data = pack_read(rd_start, rd_end);
      end else if (bus.cmd_op == OP_GO) begin
        push      = 1'b1;
        push_data = pack_go();
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      err_reg         <= 1'b0;
      instr_count_reg <= '0;
    end else begin
      err_reg <= cmd_fire && cmd_reject;
      if (instr_fire) instr_count_reg <= instr_count_reg + 1'b1;
      case (state_reg)
        IDLE: begin
          if (cmd_fire && bus.cmd_op == OP_WRITE) begin
            addr_reg      <= bus.cmd_addr;
            remaining_reg <= bus.cmd_len;
            state_reg     <= WRITE;
          end
        end
        WRITE: begin
          if (wdata_fire) begin
            // Address wraps naturally at the field width.
            addr_reg <= addr_reg + 1'b1;
            if (remaining_reg == '0) state_reg <= IDLE;
            else remaining_reg <= remaining_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  instr_fifo #(
    .WIDTH (INSTR_LENGTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.instr_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_head;
  assign bus.busy        = (state_reg != IDLE) || !fifo_empty;
  assign bus.err         = err_reg;
  assign bus.instr_count = instr_count_reg;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: bursts, reads, rejects, backpressure
// and reset in the middle of a burst.
module tb_instruction_encoder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   delivered;
  int   cyc;
  logic fire_i;
  logic fire_c;

  instruction_encoder_if bus ();

  instruction_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [13:0] a,
                          input logic [13:0] e, input logic [7:0] len);
    int n;
    n = 0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = op;
    bus.cmd_addr     = a;
    bus.cmd_end_addr = e;
    bus.cmd_len      = len;
    while (!bus.cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_accept_in_time", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    $display("cmd op=%b addr=%h end=%h len=%0d accepted", op, a, e, len);
  endtask

  task automatic send_wdata(input logic [15:0] d);
    int n;
    n = 0;
    bus.wdata_valid = 1'b1;
    bus.wdata       = d;
    while (!bus.wdata_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("wdata_accept_in_time", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bus.wdata_valid = 1'b0;
    $display("wdata %h accepted", d);
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    while (!bus.instr_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    check(tag, bus.instr, exp);
    bus.instr_ready = 1'b1;
    @(posedge clk); #1;
    bus.instr_ready = 1'b0;
    $display("instr %h popped (%s)", exp, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = 2'b00;
    bus.cmd_addr     = '0;
    bus.cmd_end_addr = '0;
    bus.cmd_len      = '0;
    bus.wdata_valid  = 1'b0;
    bus.wdata        = '0;
    bus.instr_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr",       bus.instr,            32'd0);
    check("rst_cmd_ready",   32'(bus.cmd_ready),   32'd0);
    check("rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check("rst_err",         32'(bus.err),         32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_count",       32'(bus.instr_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Write burst crossing the address wrap
    send_cmd(2'b00, 14'h3FFE, 14'h0000, 8'd2);
    check("wr_wdata_ready", 32'(bus.wdata_ready), 32'd1);
    check("wr_cmd_ready",   32'(bus.cmd_ready),   32'd0);
    check("wr_busy",        32'(bus.busy),        32'd1);
    check("wr_no_push",     32'(bus.instr_valid), 32'd0);
    send_wdata(16'h000A);
    send_wdata(16'h000B);
    send_wdata(16'h000C);
    check("wr_done_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check("wr_done_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    pop_expect("wr_word0", 32'h3FFE000A);
    pop_expect("wr_word1", 32'h3FFF000B);
    pop_expect("wr_word2", 32'h0000000C);
    check("wr_count", 32'(bus.instr_count), 32'd3);
    check("wr_idle_busy", 32'(bus.busy), 32'd0);
    check("wr_empty_instr", bus.instr, 32'd0);

    // Read range
    send_cmd(2'b01, 14'h0010, 14'h0020, 8'd0);
    check("rd_valid", 32'(bus.instr_valid), 32'd1);
    check("rd_word",  bus.instr,            32'h40080020);
    check("rd_err",   32'(bus.err),         32'd0);
    pop_expect("rd_pop", 32'h40080020);

    // Read with start == end at the top of the range
    send_cmd(2'b01, 14'h3FFF, 14'h3FFF, 8'd0);
    check("rd_eq_err", 32'(bus.err), 32'd0);
    pop_expect("rd_eq_word", 32'h5FFFBFFF);
    check("rd_count", 32'(bus.instr_count), 32'd5);

    // Rejected read
    send_cmd(2'b01, 14'h0021, 14'h0020, 8'd0);
    check("rej_err",   32'(bus.err),         32'd1);
    check("rej_valid", 32'(bus.instr_valid), 32'd0);
    @(posedge clk); #1;
    check("rej_err_clear", 32'(bus.err),         32'd0);
    check("rej_count",     32'(bus.instr_count), 32'd5);

    // Illegal opcode
    send_cmd(2'b11, 14'h0000, 14'h0000, 8'd0);
    check("ill_err",   32'(bus.err),         32'd1);
    check("ill_valid", 32'(bus.instr_valid), 32'd0);
    @(posedge clk); #1;
    check("ill_err_clear", 32'(bus.err), 32'd0);

    // Backpressure: fill FIFO with go words
    for (int i = 0; i < 4; i++) send_cmd(2'b10, 14'h0000, 14'h0000, 8'd0);
    check("bp_full_cmd_ready", 32'(bus.cmd_ready),   32'd0);
    check("bp_valid",          32'(bus.instr_valid), 32'd1);
    check("bp_head",           bus.instr,            32'h80000000);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    check("bp_held_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("bp_head_stable",    bus.instr,          32'h80000000);
    check("bp_count_hold",     32'(bus.instr_count), 32'd5);
    bus.instr_ready = 1'b1;
    delivered = 0;
    cyc = 0;
    while (delivered < 5 && cyc < 30) begin
      if (bus.instr_valid) check("bp_word", bus.instr, 32'h80000000);
      fire_i = bus.instr_valid && bus.instr_ready;
      fire_c = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk); #1;
      if (fire_i) begin
        delivered++;
        $display("go word %0d delivered", delivered);
      end
      if (fire_c) bus.cmd_valid = 1'b0;
      cyc++;
    end
    bus.instr_ready = 1'b0;
    check("bp_delivered", 32'(delivered), 32'd5);
    check("bp_count",     32'(bus.instr_count), 32'd10);
    check("bp_drained",   32'(bus.instr_valid), 32'd0);

    // Reset in the middle of a burst
    send_cmd(2'b00, 14'h0100, 14'h0000, 8'd2);
    send_wdata(16'h1234);
    check("mid_valid_before", 32'(bus.instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("mid_rst_busy",  32'(bus.busy),        32'd0);
    check("mid_rst_count", 32'(bus.instr_count), 32'd0);
    check("mid_rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check("mid_rst_instr", bus.instr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
    check("post_rst_wdata_ready", 32'(bus.wdata_ready), 32'd0);
    send_cmd(2'b01, 14'h0005, 14'h0007, 8'd0);
    pop_expect("post_rst_rd", 32'h40028007);
    check("post_rst_count", 32'(bus.instr_count), 32'd1);
    check("post_rst_empty", 32'(bus.instr_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
